lut_sram_arbiter: RTL and testbench
===================================

// Module: lut_sram_arbiter
// PURPOSE
//  Owns the single-port 16x16 lookup SRAM. Arbitrates it between the flash-to-SRAM loader (write, absolute
//  priority) and two DDS read requesters (round-robin). Replaces the ad-hoc busy mux in top and lets a second
//  DDS channel share the same sine table. Sits between the loader/DDS cores and the sram16x16 instance.
// PARAMETERS
//  AW      16  SRAM address width
//  DW      16  SRAM data width
//  RD_LAT  1   SRAM read latency, cycles from sram_addr registered to sram_dout valid (1..3)
// PORTS
//  clk         in   1   system clock (PLL clock); sole clock of the block
//  rst         in   1   asynchronous, active-high reset
//  ld_busy     in   1   loader owns table while high (Flash_to_SRAM busy)
//  ld_wen      in   1   loader write strobe, qualified by ld_busy
//  ld_addr     in   AW  loader write address
//  ld_wdata    in   DW  loader write data
//  rd_req      in   2   per-channel read request, held until rd_gnt
//  rd_addr0    in   AW  channel 0 read address, stable while rd_req[0]
//  rd_addr1    in   AW  channel 1 read address, stable while rd_req[1]
//  rd_gnt      out  2   one-cycle pulse: request accepted, address sampled
//  rd_valid    out  2   one-cycle pulse: rd_data for that channel is valid
//  rd_data     out  DW  read data, shared bus, tagged by rd_valid
//  sram_wen    out  1   to SRAM write enable
//  sram_addr   out  AW  to SRAM address
//  sram_wdata  out  DW  to SRAM write data
//  sram_dout   in   DW  from SRAM read data
//  load_done   out  1   one-cycle pulse on LOAD exit
// BEHAVIOUR
//  Reset (async): all outputs 0; state IDLE; rr pointer = channel 0 preferred; tag pipe cleared.
//  SRAM outputs registered: command issued in cycle N appears on sram_* in N+1.
//  FSM: IDLE -> LOAD when ld_busy=1 (checked first every cycle, regardless of pending reads).
//       IDLE -> SERVE when ld_busy=0 and rd_req!=0. SERVE -> IDLE after grant if no req remains.
//       LOAD -> DRAIN when ld_busy falls; DRAIN lasts 1 cycle, pulses load_done, -> IDLE.
//  LOAD: sram_wen/addr/wdata <= ld_wen/ld_addr/ld_wdata each cycle; rd_gnt forced 0; reads stall.
//  SERVE: at most one grant per cycle (one SRAM access/cycle, back-to-back allowed).
//    Only one req -> grant it. Both -> grant channel != last granted; rr pointer updates on every grant.
//    Grant cycle: sram_addr <= granted rd_addr, sram_wen <= 0.
//  Read return: rd_valid[ch] and rd_data asserted exactly RD_LAT+1 cycles after rd_gnt[ch];
//    rd_data holds last value between valids. Fixed latency; no backpressure on read return.
//  Reads already granted when ld_busy rises still complete with correct valid/data
//    (SRAM write starts the cycle after the last read address issue -- no collision by construction).
//  ld_wen while ld_busy=0: ignored. rd_req dropped before grant: legal, no grant issued.
//  Both rd_req and ld_busy rise same cycle: loader wins, no grant that cycle.
//  Starvation bound: with ld_busy=0, a held request is granted within 2 cycles.
//  Address widths pass through unmodified; no wrap arithmetic inside the block.
// STRUCTURE
//  Shared package lut_pkg: AW/DW defaults, state encoding (IDLE, SERVE, LOAD, DRAIN), channel IDs CH0/CH1.
//  Sub-module rd_tag_pipe: RD_LAT+1-deep shift register of {valid, channel}; drives rd_valid demux.
//  Top of block: FSM + rr arbiter + registered SRAM command mux + rd_data capture.
// TESTING
//  1 Reset mid-read: rd_req=01 granted, assert rst next cycle -> all outputs 0, no rd_valid ever appears.
//  2 Single read: preload mem[0x0010]=0xBEEF, rd_req=01 addr 0x0010 -> rd_gnt=01 cycle N, rd_valid=01,
//    rd_data=0xBEEF at N+RD_LAT+1.
//  3 Contention: rd_req=11 held 6 cycles -> grants alternate 01,10,01,10... starting per rr pointer; each valid
//    carries its own channel's data.
//  4 Load priority: ld_busy=1 with rd_req=11 pending, 4 writes 0x0000..0x0003 -> sram_wen mirrors ld_wen,
//    rd_gnt=00 throughout; load_done pulses once after ld_busy falls; reads then return new data.
//  5 Load during in-flight read: grant at N, ld_busy rises N+1 -> read returns pre-load data at N+RD_LAT+1,
//    first loader write on sram bus no earlier than N+2.
//  6 Ignored write: ld_wen=1, ld_busy=0, ld_addr=0x0005 -> sram_wen stays 0, mem[0x0005] unchanged.

Source files
------------

// File: rtl/lut_pkg.sv
// rtl/lut_pkg.sv - shared types and defaults for the lookup-SRAM arbiter
package lut_pkg;

  localparam int AW_DEF = 16;
  localparam int DW_DEF = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERVE = 2'd1,
    LOAD  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  localparam logic CH0 = 1'b0;
  localparam logic CH1 = 1'b1;

  typedef struct packed {
    logic valid;
    logic ch;
  } rd_tag_t;

  function automatic logic [1:0] ch_onehot(input logic ch);
    return ch ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/rd_tag_pipe.sv
// rtl/rd_tag_pipe.sv - delays the {valid, channel} tag of each read grant to line up with SRAM data
module rd_tag_pipe
  import lut_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  rd_tag_t    tag_in,
  output logic       cap_en,
  output logic [1:0] rd_valid
);

  // Stage k is visible k+1 cycles after the grant; stage RD_LAT-1 is the cycle sram_dout holds the word.
  rd_tag_t [RD_LAT:0] stage;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage <= '0;
    end else begin
      stage <= {stage[RD_LAT-1:0], tag_in};
    end
  end

  always_comb begin
    cap_en   = stage[RD_LAT-1].valid;
    rd_valid = stage[RD_LAT].valid ? ch_onehot(stage[RD_LAT].ch) : 2'b00;
  end

endmodule

// File: rtl/lut_sram_arbiter.sv
// rtl/lut_sram_arbiter.sv - owns the lookup SRAM: loader writes with absolute priority, two readers round-robin
module lut_sram_arbiter
  import lut_pkg::*;
#(
  parameter int AW     = AW_DEF,
  parameter int DW     = DW_DEF,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ld_busy,
  input  logic          ld_wen,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_wdata,
  input  logic [1:0]    rd_req,
  input  logic [AW-1:0] rd_addr0,
  input  logic [AW-1:0] rd_addr1,
  output logic [1:0]    rd_gnt,
  output logic [1:0]    rd_valid,
  output logic [DW-1:0] rd_data,
  output logic          sram_wen,
  output logic [AW-1:0] sram_addr,
  output logic [DW-1:0] sram_wdata,
  input  logic [DW-1:0] sram_dout,
  output logic          load_done
);

  state_t        state, state_nxt;
  logic          last_ch;
  logic [1:0]    gnt;
  logic          gnt_ch;
  logic          cmd_wen;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  rd_tag_t       tag_in;
  logic          cap_en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ld_busy is tested ahead of reads in every state so the loader never waits on the readers.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (ld_busy)      state_nxt = LOAD;
        else if (|rd_req) state_nxt = SERVE;
      end
      SERVE: begin
        if (ld_busy)                    state_nxt = LOAD;
        else if ((rd_req & ~gnt) == '0) state_nxt = IDLE;
      end
      LOAD: begin
        if (!ld_busy) state_nxt = DRAIN;
      end
      DRAIN:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    gnt       = 2'b00;
    gnt_ch    = last_ch;
    cmd_wen   = 1'b0;
    cmd_addr  = sram_addr;
    cmd_wdata = sram_wdata;
    if (state == SERVE && !ld_busy) begin
      case (rd_req)
        2'b01:   gnt_ch = CH0;
        2'b10:   gnt_ch = CH1;
        2'b11:   gnt_ch = ~last_ch;
        default: gnt_ch = last_ch;
      endcase
      if (|rd_req) begin
        gnt      = ch_onehot(gnt_ch);
        cmd_addr = gnt_ch ? rd_addr1 : rd_addr0;
      end
    end else if (state == LOAD) begin
      cmd_wen   = ld_wen & ld_busy;
      cmd_addr  = ld_addr;
      cmd_wdata = ld_wdata;
    end
    tag_in.valid = |gnt;
    tag_in.ch    = gnt_ch;
  end

  assign rd_gnt    = gnt;
  assign load_done = (state == DRAIN);

  // Pointer holds the last granted channel; reset to CH1 so channel 0 wins the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_ch <= CH1;
    end else if (|gnt) begin
      last_ch <= gnt_ch;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sram_wen   <= 1'b0;
      sram_addr  <= '0;
      sram_wdata <= '0;
    end else begin
      sram_wen   <= cmd_wen;
      sram_addr  <= cmd_addr;
      sram_wdata <= cmd_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data <= '0;
    end else if (cap_en) begin
      rd_data <= sram_dout;
    end
  end

  rd_tag_pipe #(
    .RD_LAT(RD_LAT)
  ) u_tag_pipe (
    .clk     (clk),
    .rst     (rst),
    .tag_in  (tag_in),
    .cap_en  (cap_en),
    .rd_valid(rd_valid)
  );

endmodule

// File: tb/tb_lut_sram_arbiter.sv
// tb/tb_lut_sram_arbiter.sv - directed bench with SRAM model and read-return scoreboard
module tb_lut_sram_arbiter;

  localparam int AW     = 16;
  localparam int DW     = 16;
  localparam int RD_LAT = 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          ld_busy, ld_wen;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_wdata;
  logic [1:0]    rd_req;
  logic [AW-1:0] rd_addr0, rd_addr1;
  logic [1:0]    rd_gnt, rd_valid;
  logic [DW-1:0] rd_data;
  logic          sram_wen;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_wdata;
  logic [DW-1:0] sram_dout;
  logic          load_done;

  logic          bd_we;
  logic [AW-1:0] bd_addr;
  logic [DW-1:0] bd_data;
  logic [DW-1:0] mem     [0:65535];
  logic [DW-1:0] ref_mem [0:65535];
  logic [DW-1:0] rdq1, rdq2;

  typedef struct {
    logic          ch;
    logic [DW-1:0] data;
    int            due;
  } exp_t;
  exp_t sbq[$];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (bd_we)         mem[bd_addr]   <= bd_data;
    else if (sram_wen) mem[sram_addr] <= sram_wdata;
    rdq1 <= mem[sram_addr];
    rdq2 <= rdq1;
  end
  assign sram_dout = (RD_LAT == 1) ? mem[sram_addr] : (RD_LAT == 2) ? rdq1 : rdq2;

  lut_sram_arbiter #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .ld_busy   (ld_busy),
    .ld_wen    (ld_wen),
    .ld_addr   (ld_addr),
    .ld_wdata  (ld_wdata),
    .rd_req    (rd_req),
    .rd_addr0  (rd_addr0),
    .rd_addr1  (rd_addr1),
    .rd_gnt    (rd_gnt),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .sram_wen  (sram_wen),
    .sram_addr (sram_addr),
    .sram_wdata(sram_wdata),
    .sram_dout (sram_dout),
    .load_done (load_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic sb_check();
    if (sbq.size() > 0 && sbq[0].due == cyc) begin
      chk("rd_valid", 32'(rd_valid), 32'(sbq[0].ch ? 2'b10 : 2'b01));
      chk("rd_data", 32'(rd_data), 32'(sbq[0].data));
      void'(sbq.pop_front());
    end else begin
      chk("rd_valid_quiet", 32'(rd_valid), 32'(2'b00));
    end
  endtask

  task automatic smp();
    @(negedge clk);
    sb_check();
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic cycle(input int n);
    for (int k = 0; k < n; k++) begin
      smp();
      adv();
    end
  endtask

  task automatic expect_grant(input logic [1:0] g);
    exp_t e;
    chk("rd_gnt", 32'(rd_gnt), 32'(g));
    if (g != 2'b00) begin
      e.ch   = g[1];
      e.data = g[1] ? ref_mem[rd_addr1] : ref_mem[rd_addr0];
      e.due  = cyc + RD_LAT + 1;
      sbq.push_back(e);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_gnt"},   32'(rd_gnt),     32'd0);
    chk({tag, "_valid"}, 32'(rd_valid),   32'd0);
    chk({tag, "_data"},  32'(rd_data),    32'd0);
    chk({tag, "_wen"},   32'(sram_wen),   32'd0);
    chk({tag, "_addr"},  32'(sram_addr),  32'd0);
    chk({tag, "_wdata"}, 32'(sram_wdata), 32'd0);
    chk({tag, "_done"},  32'(load_done),  32'd0);
  endtask

  task automatic bd_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bd_we   = 1'b1;
    bd_addr = a;
    bd_data = d;
    ref_mem[a] = d;
    smp();
    adv();
    bd_we = 1'b0;
  endtask

  task automatic single_read(input logic ch, input logic [AW-1:0] a);
    if (ch) rd_addr1 = a;
    else    rd_addr0 = a;
    rd_req = ch ? 2'b10 : 2'b01;
    smp();
    expect_grant(2'b00);
    adv();
    smp();
    expect_grant(ch ? 2'b10 : 2'b01);
    adv();
    rd_req = 2'b00;
    cycle(3);
  endtask

  initial begin
    rst = 1'b1; ld_busy = 1'b0; ld_wen = 1'b0; ld_addr = '0; ld_wdata = '0;
    rd_req = 2'b00; rd_addr0 = '0; rd_addr1 = '0;
    bd_we = 1'b0; bd_addr = '0; bd_data = '0;
    smp();
    check_all_zero("reset");
    adv();
    bd_write(16'h0010, 16'hBEEF);
    bd_write(16'h0020, 16'h1234);
    bd_write(16'h0000, 16'hA000);
    bd_write(16'h0001, 16'hA001);
    bd_write(16'h0005, 16'h5555);
    bd_write(16'h0030, 16'h7777);
    rst = 1'b0;
    cycle(2);

    // single read
    rd_addr0 = 16'h0010;
    rd_req   = 2'b01;
    smp(); expect_grant(2'b00); adv();
    smp(); expect_grant(2'b01); adv();
    rd_req = 2'b00;
    smp();
    chk("rd_cmd_addr", 32'(sram_addr), 32'h0010);
    chk("rd_cmd_wen", 32'(sram_wen), 32'd0);
    adv();
    cycle(3);

    // contention: channel 0 went last, so channel 1 leads
    rd_addr0 = 16'h0010;
    rd_addr1 = 16'h0020;
    rd_req   = 2'b11;
    smp(); expect_grant(2'b00); adv();
    for (int i = 0; i < 6; i++) begin
      smp();
      expect_grant((i % 2 == 0) ? 2'b10 : 2'b01);
      adv();
    end
    rd_req = 2'b00;
    smp(); expect_grant(2'b00); adv();
    cycle(3);

    // loader write strobe while not busy is ignored
    ld_wen = 1'b1; ld_addr = 16'h0005; ld_wdata = 16'hDEAD;
    smp(); chk("ign_done", 32'(load_done), 32'd0); adv();
    smp(); chk("ign_wen", 32'(sram_wen), 32'd0); adv();
    ld_wen = 1'b0;
    cycle(2);
    single_read(1'b1, 16'h0005);

    // load priority over pending reads
    rd_addr0 = 16'h0000;
    rd_addr1 = 16'h0001;
    rd_req   = 2'b11;
    ld_busy  = 1'b1;
    smp(); expect_grant(2'b00); adv();
    for (int i = 0; i < 5; i++) begin
      if (i < 4) begin
        ld_wen   = 1'b1;
        ld_addr  = 16'(i);
        ld_wdata = 16'hC000 + 16'(i);
        ref_mem[ld_addr] = ld_wdata;
      end else begin
        ld_wen = 1'b0;
      end
      smp();
      expect_grant(2'b00);
      chk("ld_done_busy", 32'(load_done), 32'd0);
      if (i > 0) begin
        chk("ld_wen", 32'(sram_wen), 32'd1);
        chk("ld_addr", 32'(sram_addr), 32'(i - 1));
        chk("ld_wdata", 32'(sram_wdata), 32'h0000C000 + 32'(i - 1));
      end
      adv();
    end
    ld_busy = 1'b0;
    smp(); expect_grant(2'b00); chk("ld_wen_off", 32'(sram_wen), 32'd0);
    chk("ld_done_pre", 32'(load_done), 32'd0); adv();
    smp(); expect_grant(2'b00); chk("ld_done", 32'(load_done), 32'd1); adv();
    smp(); expect_grant(2'b00); chk("ld_done_post", 32'(load_done), 32'd0); adv();
    smp(); expect_grant(2'b01); adv();
    smp(); expect_grant(2'b10); adv();
    rd_req = 2'b00;
    smp(); expect_grant(2'b00); adv();
    cycle(3);

    // load rises the cycle after a grant: the read still returns pre-load data
    rd_addr0 = 16'h0030;
    rd_req   = 2'b01;
    smp(); expect_grant(2'b00); adv();
    smp(); expect_grant(2'b01); adv();
    rd_req = 2'b00; ld_busy = 1'b1; ld_wen = 1'b1; ld_addr = 16'h0030; ld_wdata = 16'h9999;
    ref_mem[16'h0030] = 16'h9999;
    smp();
    expect_grant(2'b00);
    chk("inflight_wen", 32'(sram_wen), 32'd0);
    chk("inflight_addr", 32'(sram_addr), 32'h0030);
    adv();
    cycle(2);
    ld_busy = 1'b0; ld_wen = 1'b0;
    cycle(3);
    single_read(1'b0, 16'h0030);

    // reset while a read is in flight: its return must never appear
    rd_addr0 = 16'h0010;
    rd_req   = 2'b01;
    smp(); expect_grant(2'b00); adv();
    smp(); expect_grant(2'b01); adv();
    rst = 1'b1; rd_req = 2'b00;
    sbq.delete();
    smp();
    check_all_zero("midrst");
    adv();
    rst = 1'b0;
    cycle(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
